// File: rtl/result_dec_tx.sv
// result_dec_tx: prints a 32-bit unsigned result as decimal ASCII on a valid/ready byte stream
//   CLK, Init (sync active-high reset)       : clock and reset
//   Start, Value[31:0]                       : result-ready level and the value captured on its rising edge
//   Data[7:0], Valid, Ready                  : character stream, one beat per Valid && Ready edge
//   Busy, Done                               : conversion/transmission in progress, printout finished
module result_dec_tx #(
  parameter bit EMIT_NEWLINE = 1'b1
) (
  input  logic        CLK,
  input  logic        Init,
  input  logic        Start,
  input  logic [31:0] Value,
  output logic [7:0]  Data,
  output logic        Valid,
  input  logic        Ready,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [2:0] {IDLE, CONVERT, SEND, CR, LF, FIN} state_t;
  state_t      state_q = IDLE;
  state_t      state_d;
  logic        prev_q = 1'b1;
  logic [31:0] val_q = '0;
  logic [31:0] val_d;
  logic [39:0] bcd_q = '0;
  logic [39:0] bcd_d;
  logic [39:0] adj;
  logic [5:0]  cnt_q = '0;
  logic [5:0]  cnt_d;
  logic [3:0]  idx_q = '0;
  logic [3:0]  idx_d;
  logic [3:0]  msd;
  logic [3:0]  dig;
  logic        cap;
  // previous Start resets high so a level already present at Init is not taken as an edge
  always_ff @(posedge CLK) begin
    prev_q  <= Init ? 1'b1 : Start;
    state_q <= Init ? IDLE : state_d;
    val_q   <= Init ? '0 : val_d;
    bcd_q   <= Init ? '0 : bcd_d;
    cnt_q   <= Init ? '0 : cnt_d;
    idx_q   <= Init ? '0 : idx_d;
  end
  assign cap = (state_q == IDLE || state_q == FIN) && Start && !prev_q;
  // add-3 correction of every digit and most significant non-zero digit position
  always_comb begin
    adj = '0;
    msd = '0;
    for (int i = 0; i < 10; i++) begin
      adj[i*4 +: 4] = bcd_q[i*4 +: 4] >= 4'd5 ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
      if (bcd_q[i*4 +: 4] != 4'd0) msd = 4'(i);
    end
  end
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, FIN: if (cap) begin
        state_d = CONVERT;
        val_d   = Value;
        bcd_d   = '0;
        cnt_d   = '0;
      end
      // 32 shift steps, then one cycle to pick the leading digit from the finished BCD
      CONVERT: if (cnt_q == 6'd32) begin
        state_d = SEND;
        idx_d   = msd;
      end else begin
        {bcd_d, val_d} = {adj, val_q} << 1;
        cnt_d = cnt_q + 6'd1;
      end
      SEND: if (Ready) begin
        idx_d = idx_q - 4'd1;
        if (idx_q == 4'd0) state_d = EMIT_NEWLINE ? CR : FIN;
      end
      CR: if (Ready) state_d = LF;
      LF: if (Ready) state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    Valid = state_q == SEND || state_q == CR || state_q == LF;
    Busy  = Valid || state_q == CONVERT;
    Done  = state_q == FIN;
    dig   = bcd_q[{idx_q, 2'b00} +: 4];
    Data  = state_q == SEND ? {4'h3, dig} : state_q == CR ? 8'h0D : state_q == LF ? 8'h0A : 8'h00;
  end
endmodule

// File: tb/tb_result_dec_tx.sv
// tb_result_dec_tx: directed checks of decimal printout, handshake stalls, re-arm and abort
module tb_result_dec_tx;
  logic        CLK = 1'b0;
  logic        Init = 1'b1;
  logic        Start = 1'b0;
  logic        Ready = 1'b0;
  logic [31:0] Value = '0;
  logic [7:0]  data1, data2, d;
  logic        valid1, valid2, busy1, busy2, done1, done2, v, b, dn;
  bit          sel = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          nv;

  always #5 CLK = ~CLK;

  result_dec_tx #(.EMIT_NEWLINE(1'b1)) u_nl (
    .CLK(CLK), .Init(Init), .Start(Start), .Value(Value),
    .Data(data1), .Valid(valid1), .Ready(Ready), .Busy(busy1), .Done(done1)
  );
  result_dec_tx #(.EMIT_NEWLINE(1'b0)) u_raw (
    .CLK(CLK), .Init(Init), .Start(Start), .Value(Value),
    .Data(data2), .Valid(valid2), .Ready(Ready), .Busy(busy2), .Done(done2)
  );

  assign d  = sel ? data2 : data1;
  assign v  = sel ? valid2 : valid1;
  assign b  = sel ? busy2 : busy1;
  assign dn = sel ? done2 : done1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [31:0] val, input string digits, input bit nl, input bit stall);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] held;
    int lat, bub, k;
    bit pend;
    foreach (digits[i]) exp_q.push_back(digits[i]);
    if (nl) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    Value = val; Ready = 1'b1; Start = 1'b0;
    tick;
    Start = 1'b1;
    tick;
    check("busy_cap", b, 1);
    check("done_clr", dn, 0);
    lat = 0;
    while (!v && lat < 100) begin
      tick;
      lat++;
    end
    check("latency", lat, 33);
    bub = 0; pend = 1'b0; k = 0; held = '0;
    while (!dn && k < 200) begin
      if (pend) begin
        check("hold_data", d, held);
        check("hold_valid", v, 1);
      end
      if (!v) bub++;
      Ready = stall ? (k % 3 == 0) : 1'b1;
      if (v && Ready) got_q.push_back(d);
      pend = v && !Ready;
      held = d;
      tick;
      k++;
    end
    check("done", dn, 1);
    check("busy_end", b, 0);
    check("bubbles", bub, 0);
    check("len", got_q.size(), exp_q.size());
    foreach (exp_q[i]) check("beat", i < got_q.size() ? got_q[i] : 8'h00, exp_q[i]);
    check("data_idle", d, 0);
    check("valid_idle", v, 0);
    Ready = 1'b1;
  endtask

  initial begin
    int lat;
    #1;
    check("pre_valid", v, 0);
    check("pre_busy", b, 0);
    check("pre_done", dn, 0);
    check("pre_data", d, 0);
    tick;
    tick;
    check("rst_valid", v, 0);
    check("rst_busy", b, 0);
    check("rst_done", dn, 0);
    Init = 1'b0;
    tick;
    run(32'd233168, "233168", 1'b1, 1'b0);
    nv = 0;
    for (int i = 0; i < 200; i++) begin
      if (v) nv++;
      tick;
    end
    check("hold_no_valid", nv, 0);
    check("hold_done", dn, 1);
    run(32'd7, "7", 1'b1, 1'b0);
    run(32'd0, "0", 1'b1, 1'b0);
    run(32'hFFFF_FFFF, "4294967295", 1'b1, 1'b0);
    run(32'd1000, "1000", 1'b1, 1'b1);
    Value = 32'd233168; Start = 1'b0;
    tick;
    Start = 1'b1;
    tick;
    lat = 0;
    while (!v && lat < 100) begin
      tick;
      lat++;
    end
    check("abort_latency", lat, 33);
    tick;
    tick;
    check("abort_third", d, 8'h33);
    Init = 1'b1;
    tick;
    check("abort_valid", v, 0);
    check("abort_busy", b, 0);
    check("abort_done", dn, 0);
    check("abort_data", d, 0);
    Init = 1'b0;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      if (v || b) nv++;
      tick;
    end
    check("init_start_quiet", nv, 0);
    sel = 1'b1;
    run(32'd42, "42", 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
